// File: rtl/sdc_host_pkg.sv
// Shared definitions for the SD command host sequencer: slave register map,
// status bits, FSM encoding, error/response codes and the CRC7 helper.
package sdc_host_pkg;

    localparam logic [2:0] ADR_TX_CMD = 3'd0;
    localparam logic [2:0] ADR_RX_CMD = 3'd1;
    localparam logic [2:0] ADR_STATUS = 3'd4;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_EMPTY = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_POLL = 3'd1,
        ST_TX_WR   = 3'd2,
        ST_RX_POLL = 3'd3,
        ST_RX_RD   = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_POLL = 2'b01;
    localparam logic [1:0] ERR_BUS  = 2'b10;

    localparam logic [1:0] RSP_NONE  = 2'd0;
    localparam logic [1:0] RSP_SHORT = 2'd1;
    localparam logic [1:0] RSP_LONG  = 2'd2;
    localparam logic [1:0] RSP_RSVD  = 2'd3;

    localparam logic [4:0] RSP_SHORT_BYTES = 5'd6;
    localparam logic [4:0] RSP_LONG_BYTES  = 5'd17;

    // SD CRC7 (x^7 + x^3 + 1), zero init, MSB of the 40-bit field first.
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

endpackage

// File: rtl/sdc_cmd_host_seq_if.sv
// Wishbone classic bus between the command sequencer (master) and the SD
// FIFO controller register file (slave).
interface sdc_cmd_host_seq_if;
    logic [2:0] m_wb_adr_o;
    logic [7:0] m_wb_dat_o;
    logic [7:0] m_wb_dat_i;
    logic [3:0] m_wb_sel_o;
    logic       m_wb_we_o;
    logic       m_wb_cyc_o;
    logic       m_wb_stb_o;
    logic       m_wb_ack_i;

    modport master (
        output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
        input  m_wb_dat_i, m_wb_ack_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o,
        output m_wb_dat_i, m_wb_ack_i
    );
endinterface

// File: rtl/sdc_crc7.sv
// Combinational CRC7 over the first five command bytes.
module sdc_crc7
    import sdc_host_pkg::*;
(
    input  logic [39:0] data_i,
    output logic [6:0]  crc_o
);

    assign crc_o = crc7_calc(data_i);

endmodule

// File: rtl/sdc_cmd_host_seq.sv
// SD command host sequencer: pushes one 6-byte command into the controller's
// tx FIFO and drains the response. Optional CRC7 via SDC_CMD_HOST_CRC7_EN.
module sdc_cmd_host_seq
    import sdc_host_pkg::*;
#(
    parameter int POLL_LIMIT = 1024,
    parameter int ACK_LIMIT  = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               start_i,
    input  logic [5:0]         cmd_idx_i,
    input  logic [31:0]        cmd_arg_i,
    input  logic [1:0]         rsp_len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         err_o,
    output logic [135:0]       rsp_o,
    sdc_cmd_host_seq_if.master m_wb
);

    localparam logic [15:0] POLL_LIM   = 16'(POLL_LIMIT);
    localparam logic [15:0] ACK_LIM_M1 = 16'(ACK_LIMIT - 1);

    state_e         state_q;
    logic [5:0]     cmd_idx_q;
    logic [31:0]    cmd_arg_q;
    logic [1:0]     rsp_len_q;
    logic           busy_q;
    logic           done_q;
    logic [1:0]     err_q;
    logic [135:0]   rsp_q;
    logic [2:0]     byte_cnt_q;
    logic [4:0]     rcv_cnt_q;
    logic [15:0]    polls_q;
    logic [15:0]    ack_cnt_q;
    logic           cyc_q;
    logic           stb_q;
    logic           we_q;
    logic [2:0]     adr_q;
    logic [7:0]     dat_q;

    logic [6:0]     crc7_s;
    logic [7:0]     tx_byte_s;
    logic [2:0]     acc_adr_s;
    logic           acc_we_s;
    logic [7:0]     acc_dat_s;
    logic [15:0]    polls_inc_s;
    logic           poll_hit_s;
    logic [4:0]     rx_target_s;
    logic [4:0]     rcv_next_s;

`ifdef SDC_CMD_HOST_CRC7_EN
    sdc_crc7 u_crc7 (
        .data_i ({2'b01, cmd_idx_q, cmd_arg_q}),
        .crc_o  (crc7_s)
    );
`else
    assign crc7_s = 7'h00;
`endif

    // Byte currently due for the tx command FIFO.
    always_comb begin
        tx_byte_s = 8'h00;
        case (byte_cnt_q)
            3'd0:    tx_byte_s = {2'b01, cmd_idx_q};
            3'd1:    tx_byte_s = cmd_arg_q[31:24];
            3'd2:    tx_byte_s = cmd_arg_q[23:16];
            3'd3:    tx_byte_s = cmd_arg_q[15:8];
            3'd4:    tx_byte_s = cmd_arg_q[7:0];
            3'd5:    tx_byte_s = {crc7_s, 1'b1};
            default: tx_byte_s = 8'h00;
        endcase
    end

    // Address, direction and data of the access each bus state issues.
    always_comb begin
        acc_adr_s = 3'd0;
        acc_we_s  = 1'b0;
        acc_dat_s = 8'h00;
        case (state_q)
            ST_TX_POLL, ST_RX_POLL: acc_adr_s = ADR_STATUS;
            ST_TX_WR: begin
                acc_adr_s = ADR_TX_CMD;
                acc_we_s  = 1'b1;
                acc_dat_s = tx_byte_s;
            end
            ST_RX_RD: acc_adr_s = ADR_RX_CMD;
            default:  acc_adr_s = 3'd0;
        endcase
    end

    // Poll accounting (saturating) and response byte bookkeeping.
    always_comb begin
        if (polls_q == 16'hFFFF) begin
            polls_inc_s = polls_q;
        end else begin
            polls_inc_s = polls_q + 16'd1;
        end
        poll_hit_s = (polls_inc_s >= POLL_LIM);
        rcv_next_s = rcv_cnt_q + 5'd1;
        case (rsp_len_q)
            RSP_SHORT: rx_target_s = RSP_SHORT_BYTES;
            RSP_LONG:  rx_target_s = RSP_LONG_BYTES;
            default:   rx_target_s = 5'd0;
        endcase
    end

    // Sequencer FSM; each bus state issues one access after an idle cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            cmd_idx_q  <= 6'd0;
            cmd_arg_q  <= 32'd0;
            rsp_len_q  <= RSP_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_OK;
            rsp_q      <= 136'd0;
            byte_cnt_q <= 3'd0;
            rcv_cnt_q  <= 5'd0;
            polls_q    <= 16'd0;
            ack_cnt_q  <= 16'd0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 3'd0;
            dat_q      <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (start_i) begin
                        cmd_idx_q  <= cmd_idx_i;
                        cmd_arg_q  <= cmd_arg_i;
                        rsp_len_q  <= (rsp_len_i == RSP_RSVD) ? RSP_NONE : rsp_len_i;
                        rsp_q      <= 136'd0;
                        err_q      <= ERR_OK;
                        busy_q     <= 1'b1;
                        byte_cnt_q <= 3'd0;
                        rcv_cnt_q  <= 5'd0;
                        polls_q    <= 16'd0;
                        state_q    <= ST_TX_POLL;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TX_POLL, ST_TX_WR, ST_RX_POLL, ST_RX_RD: begin
                    if (!stb_q) begin
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        adr_q     <= acc_adr_s;
                        we_q      <= acc_we_s;
                        dat_q     <= acc_dat_s;
                        ack_cnt_q <= 16'd0;
                    end else if (m_wb.m_wb_ack_i) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        adr_q <= 3'd0;
                        dat_q <= 8'h00;
                        case (state_q)
                            ST_TX_POLL: begin
                                polls_q <= polls_inc_s;
                                if (!m_wb.m_wb_dat_i[STAT_TX_FULL]) begin
                                    polls_q <= 16'd0;
                                    state_q <= ST_TX_WR;
                                end else if (poll_hit_s) begin
                                    err_q   <= ERR_POLL;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_FIN;
                                end else begin
                                    state_q <= ST_TX_POLL;
                                end
                            end
                            ST_TX_WR: begin
                                byte_cnt_q <= byte_cnt_q + 3'd1;
                                polls_q    <= 16'd0;
                                if (byte_cnt_q != 3'd5) begin
                                    state_q <= ST_TX_POLL;
                                end else if (rsp_len_q != RSP_NONE) begin
                                    state_q <= ST_RX_POLL;
                                end else begin
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_FIN;
                                end
                            end
                            ST_RX_POLL: begin
                                polls_q <= polls_inc_s;
                                if (!m_wb.m_wb_dat_i[STAT_RX_EMPTY]) begin
                                    polls_q <= 16'd0;
                                    state_q <= ST_RX_RD;
                                end else if (poll_hit_s) begin
                                    err_q   <= ERR_POLL;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_FIN;
                                end else begin
                                    state_q <= ST_RX_POLL;
                                end
                            end
                            default: begin
                                rsp_q     <= {rsp_q[127:0], m_wb.m_wb_dat_i};
                                rcv_cnt_q <= rcv_next_s;
                                polls_q   <= 16'd0;
                                if (rcv_next_s == rx_target_s) begin
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= ST_FIN;
                                end else begin
                                    state_q <= ST_RX_POLL;
                                end
                            end
                        endcase
                    end else if (ack_cnt_q == ACK_LIM_M1) begin
                        // Slave is unresponsive: abandon the access and the sequence.
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        adr_q   <= 3'd0;
                        dat_q   <= 8'h00;
                        err_q   <= ERR_BUS;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign rsp_o           = rsp_q;
    assign m_wb.m_wb_adr_o = adr_q;
    assign m_wb.m_wb_dat_o = dat_q;
    assign m_wb.m_wb_sel_o = 4'b0001;
    assign m_wb.m_wb_we_o  = we_q;
    assign m_wb.m_wb_cyc_o = cyc_q;
    assign m_wb.m_wb_stb_o = stb_q;

endmodule

// File: tb/tb_sdc_cmd_host_seq.sv
// Directed bench for sdc_cmd_host_seq with a behavioural SD FIFO register-file slave.
module tb_sdc_cmd_host_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   cmd_idx = 6'd0;
    logic [31:0]  cmd_arg = 32'd0;
    logic [1:0]   rsp_len = 2'd0;
    logic         busy;
    logic         done;
    logic [1:0]   err;
    logic [135:0] rsp;

    int n_vec  = 0;
    int n_miss = 0;

    // Slave knobs (written by the stimulus only).
    int         tx_hold [0:5] = '{0, 0, 0, 0, 0, 0};
    int         rx_hold    = 0;
    bit         rx_forever = 1'b0;
    bit         no_ack     = 1'b0;
    logic [7:0] rsp_bytes [0:16];
    int         wr_base = 0;
    int         rd_base = 0;

    // Slave/monitor state (written by the always blocks only).
    logic [7:0] wlog [0:63];
    int wr_total = 0, rd_total = 0, st_tx_total = 0, st_rx_total = 0;
    int tx_streak = 0, rx_streak = 0;
    int stb_cyc_total = 0, done_total = 0;

`ifdef SDC_CMD_HOST_CRC7_EN
    localparam logic [7:0] B5_CMD0 = 8'h95;
    localparam logic [7:0] B5_CMD8 = 8'h87;
`else
    localparam logic [7:0] B5_CMD0 = 8'h01;
    localparam logic [7:0] B5_CMD8 = 8'h01;
`endif

    sdc_cmd_host_seq_if wb ();

    sdc_cmd_host_seq #(.POLL_LIMIT(8), .ACK_LIMIT(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .start_i    (start),
        .cmd_idx_i  (cmd_idx),
        .cmd_arg_i  (cmd_arg),
        .rsp_len_i  (rsp_len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .rsp_o      (rsp),
        .m_wb       (wb)
    );

    always #5 clk = ~clk;

    // Register-file slave: registered single-cycle ack, FIFO status scripted by the knobs.
    always @(posedge clk) begin
        if (!rst_n) begin
            wb.m_wb_ack_i <= 1'b0;
            wb.m_wb_dat_i <= 8'h00;
            tx_streak     <= 0;
            rx_streak     <= 0;
        end else if (wb.m_wb_ack_i) begin
            wb.m_wb_ack_i <= 1'b0;
        end else if (wb.m_wb_cyc_o && wb.m_wb_stb_o && !no_ack) begin
            wb.m_wb_ack_i <= 1'b1;
            wb.m_wb_dat_i <= 8'h00;
            if (wb.m_wb_we_o) begin
                if (wb.m_wb_adr_o == 3'd0) begin
                    if (wr_total < 64) wlog[wr_total] <= wb.m_wb_dat_o;
                    wr_total  <= wr_total + 1;
                    tx_streak <= 0;
                end
            end else if (wb.m_wb_adr_o == 3'd4) begin
                if (wr_total - wr_base < 6) begin
                    st_tx_total   <= st_tx_total + 1;
                    wb.m_wb_dat_i <= {7'd0, (tx_streak < tx_hold[wr_total - wr_base])};
                    tx_streak     <= tx_streak + 1;
                end else begin
                    st_rx_total   <= st_rx_total + 1;
                    wb.m_wb_dat_i <= {6'd0, (rx_forever || rx_streak < rx_hold), 1'b0};
                    rx_streak     <= rx_streak + 1;
                end
            end else if (wb.m_wb_adr_o == 3'd1) begin
                if (rd_total - rd_base < 17) wb.m_wb_dat_i <= rsp_bytes[rd_total - rd_base];
                rd_total  <= rd_total + 1;
                rx_streak <= 0;
            end
        end
    end

    // Strobe-cycle and done-pulse counters.
    always @(negedge clk) begin
        if (wb.m_wb_stb_o) stb_cyc_total <= stb_cyc_total + 1;
        if (done) done_total <= done_total + 1;
    end

    task automatic check_vec(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] len);
        @(negedge clk);
        cmd_idx = idx;
        cmd_arg = arg;
        rsp_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_vec(tag, 136'(seen), 136'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input logic [47:0] exp);
        logic [47:0] got;
        for (int k = 0; k < 6; k++) got[47 - 8*k -: 8] = wlog[wr_base + k];
        check_vec(tag, 136'(got), 136'(exp));
    endtask

    initial begin
        int done0, st0, stb0, rd0;
        for (int k = 0; k < 17; k++) rsp_bytes[k] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_vec("rst_busy", 136'(busy), 136'd0);
        check_vec("rst_done", 136'(done), 136'd0);
        check_vec("rst_err", 136'(err), 136'd0);
        check_vec("rst_rsp", rsp, 136'd0);
        check_vec("rst_cyc", 136'(wb.m_wb_cyc_o), 136'd0);
        check_vec("rst_stb", 136'(wb.m_wb_stb_o), 136'd0);
        check_vec("rst_sel", 136'(wb.m_wb_sel_o), 136'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0, no response, slave always ready
        wr_base = wr_total; rd0 = rd_total; st0 = st_tx_total; done0 = done_total;
        pulse_start(6'd0, 32'h0, 2'd0);
        check_vec("t1_busy", 136'(busy), 136'd1);
        wait_done("t1_done_seen");
        check_bytes("t1_bytes", {40'h40_00_00_00_00, B5_CMD0});
        check_vec("t1_nwr", 136'(wr_total - wr_base), 136'd6);
        check_vec("t1_nrd", 136'(rd_total - rd0), 136'd0);
        check_vec("t1_stat", 136'(st_tx_total - st0), 136'd6);
        check_vec("t1_done_cnt", 136'(done_total - done0), 136'd1);
        check_vec("t1_err", 136'(err), 136'd0);
        check_vec("t1_busy_end", 136'(busy), 136'd0);

        // CMD8 with R7 response, 3 empty polls per byte, plus an ignored start
        rsp_bytes[0] = 8'h48; rsp_bytes[1] = 8'h00; rsp_bytes[2] = 8'h00;
        rsp_bytes[3] = 8'h01; rsp_bytes[4] = 8'hAA; rsp_bytes[5] = 8'h13;
        rx_hold = 3;
        wr_base = wr_total; rd_base = rd_total; st0 = st_rx_total; done0 = done_total;
        pulse_start(6'd8, 32'h0000_01AA, 2'd1);
        repeat (20) @(negedge clk);
        pulse_start(6'd63, 32'hFFFF_FFFF, 2'd2);
        wait_done("t2_done_seen");
        check_bytes("t2_bytes", {40'h48_00_00_01_AA, B5_CMD8});
        check_vec("t2_rsp", rsp, 136'h4800_0001_AA13);
        check_vec("t2_nrd", 136'(rd_total - rd_base), 136'd6);
        check_vec("t2_rx_stat", 136'(st_rx_total - st0), 136'd24);
        check_vec("t2_done_cnt", 136'(done_total - done0), 136'd1);
        check_vec("t2_err", 136'(err), 136'd0);
        repeat (10) @(negedge clk);
        check_vec("t2_rsp_hold", rsp, 136'h4800_0001_AA13);
        rx_hold = 0;

        // tx FIFO full for 5 polls before B2; reserved rsp_len acts as none
        tx_hold[2] = 5;
        wr_base = wr_total; rd0 = rd_total; st0 = st_tx_total; stb0 = st_rx_total;
        pulse_start(6'd17, 32'h1234_5678, 2'd3);
        wait_done("t3_done_seen");
        check_vec("t3_b0_b4", 136'({wlog[wr_base], wlog[wr_base+1], wlog[wr_base+2], wlog[wr_base+3], wlog[wr_base+4]}),
                  136'(40'h51_12_34_56_78));
`ifndef SDC_CMD_HOST_CRC7_EN
        check_vec("t3_b5", 136'(wlog[wr_base+5]), 136'h01);
`endif
        check_vec("t3_tx_stat", 136'(st_tx_total - st0), 136'd11);
        check_vec("t3_nrd", 136'(rd_total - rd0), 136'd0);
        check_vec("t3_rx_stat", 136'(st_rx_total - stb0), 136'd0);
        check_vec("t3_rsp_clr", rsp, 136'd0);
        check_vec("t3_err", 136'(err), 136'd0);
        tx_hold[2] = 0;

        // rx FIFO never fills: poll timeout after 8 status reads
        rx_forever = 1'b1;
        wr_base = wr_total; rd0 = rd_total; st0 = st_rx_total; done0 = done_total;
        pulse_start(6'd55, 32'h0, 2'd1);
        wait_done("t4_done_seen");
        check_vec("t4_rx_stat", 136'(st_rx_total - st0), 136'd8);
        check_vec("t4_nrd", 136'(rd_total - rd0), 136'd0);
        check_vec("t4_err", 136'(err), 136'd1);
        check_vec("t4_busy", 136'(busy), 136'd0);
        check_vec("t4_done_cnt", 136'(done_total - done0), 136'd1);
        rx_forever = 1'b0;

        // Slave never acks: strobe held 16 cycles, bus error
        no_ack = 1'b1;
        wr_base = wr_total; stb0 = stb_cyc_total; done0 = done_total;
        pulse_start(6'd0, 32'h0, 2'd0);
        wait_done("t5_done_seen");
        check_vec("t5_stb_cycles", 136'(stb_cyc_total - stb0), 136'd16);
        check_vec("t5_err", 136'(err), 136'd2);
        check_vec("t5_cyc", 136'(wb.m_wb_cyc_o), 136'd0);
        check_vec("t5_nwr", 136'(wr_total - wr_base), 136'd0);
        check_vec("t5_done_cnt", 136'(done_total - done0), 136'd1);
        no_ack = 1'b0;

        // Asynchronous reset during the B2 write, then a clean rerun
        begin
            bit hit;
            hit = 1'b0;
            wr_base = wr_total;
            pulse_start(6'd0, 32'h0, 2'd0);
            for (int i = 0; i < 500 && !hit; i++) begin
                @(negedge clk);
                if (wb.m_wb_cyc_o && wb.m_wb_we_o && (wr_total - wr_base == 2)) hit = 1'b1;
            end
            check_vec("t6_reach_b2", 136'(hit), 136'd1);
            #1 rst_n = 1'b0;
            #1;
            check_vec("t6_cyc_rst", 136'(wb.m_wb_cyc_o), 136'd0);
            check_vec("t6_stb_rst", 136'(wb.m_wb_stb_o), 136'd0);
            check_vec("t6_busy_rst", 136'(busy), 136'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        wr_base = wr_total;
        pulse_start(6'd0, 32'h0, 2'd0);
        wait_done("t6_done_seen");
        check_bytes("t6_bytes", {40'h40_00_00_00_00, B5_CMD0});
        check_vec("t6_nwr", 136'(wr_total - wr_base), 136'd6);
        check_vec("t6_err", 136'(err), 136'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
